alu_operand_sequencer: RTL and testbench

//  Upstream front-end for the N-bit ALU: turns one debounced pushbutton plus the data switches into a

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_operand_sequencer_key_debounce.sv | 41 ++++
 rtl/alu_operand_sequencer.sv | 94 +++++++++
 tb/tb_alu_operand_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and ALU function-code constants for the operand sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {S_GET_A, S_GET_B, S_GET_F, S_ISSUE, S_DONE} state_t;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_ADDU = 4'b0001;
    localparam logic [3:0] F_SUB  = 4'b0010;
    localparam logic [3:0] F_SUBU = 4'b0011;
    localparam logic [3:0] F_AND  = 4'b0100;
    localparam logic [3:0] F_OR   = 4'b0101;
    localparam logic [3:0] F_XOR  = 4'b0110;
    localparam logic [3:0] F_NOR  = 4'b0111;
    localparam logic [3:0] F_SLT  = 4'b1010;
    localparam logic [3:0] F_SLTU = 4'b1011;

    // LED stage code: issue and done share the top code
    function automatic logic [1:0] stage_code(input state_t s);
        case (s)
            S_GET_A: return 2'd0;
            S_GET_B: return 2'd1;
            S_GET_F: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, counting debouncer, press-edge pulse.
module key_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed
);

    logic            sync1, sync2, db, db_d;
    logic [DB_W-1:0] cnt;

    // All key levels are active-low, so reset parks everything at "released" (1)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db    <= 1'b1;
            db_d  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            db_d  <= db;
            if (sync2 != db) begin
                if (cnt == {DB_W{1'b1}}) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pressed = db_d & ~db;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Key-driven A -> B -> F load sequencer feeding an external ALU and registering its result.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 3,
    parameter int DB_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic             clear,
    input  logic [N-1:0]     data_in,
    input  logic [3:0]       func_in,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_f,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_cout,
    input  logic             alu_ov,
    output logic [N-1:0]     res_y,
    output logic             res_c,
    output logic             res_ov,
    output logic             res_valid,
    output logic [1:0]       stage,
    output logic [CNT_W-1:0] op_count
);

    state_t state, state_nxt;
    logic   load;

    key_debounce #(.DB_W(DB_W)) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n),
        .pressed (load)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_GET_A;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_GET_A;
        end else begin
            case (state)
                S_GET_A, S_DONE: if (load) state_nxt = S_GET_B;
                S_GET_B:         if (load) state_nxt = S_GET_F;
                S_GET_F:         if (load) state_nxt = S_ISSUE;
                S_ISSUE:         state_nxt = S_DONE;
                default:         state_nxt = S_GET_A;
            endcase
        end
    end

    // clear only drops res_valid; captured operands and results stay visible
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            res_y     <= '0;
            res_c     <= 1'b0;
            res_ov    <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else if (clear) begin
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_GET_A, S_DONE: if (load) begin
                    alu_a     <= data_in;
                    res_valid <= 1'b0;
                end
                S_GET_B: if (load) alu_b <= data_in;
                S_GET_F: if (load) alu_f <= func_in;
                S_ISSUE: begin
                    res_y     <= alu_y;
                    res_c     <= alu_cout;
                    res_ov    <= alu_ov;
                    res_valid <= 1'b1;
                    op_count  <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign stage = stage_code(state);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: behavioural ALU on the alu_* ports plus a press-level sequence model.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 3, DB_W = 2, CNT_W = 2;
    localparam int HOLD = 12;

    logic             clk = 1'b0, rst_n = 1'b0, key_n = 1'b1, clear = 1'b0;
    logic [N-1:0]     data_in = '0;
    logic [3:0]       func_in = '0;
    logic [N-1:0]     alu_a, alu_b, alu_y, res_y;
    logic [3:0]       alu_f;
    logic             alu_cout, alu_ov, res_c, res_ov, res_valid;
    logic [1:0]       stage;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0, n_fail = 0, pulses = 0;

    // press-level model
    logic [2:0] m_a, m_b;
    logic [3:0] m_f;
    logic [4:0] m_res;
    logic       m_valid;
    int         m_stage, m_cnt;

    alu_operand_sequencer #(.N(N), .DB_W(DB_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .clear(clear),
        .data_in(data_in), .func_in(func_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_ov(alu_ov),
        .res_y(res_y), .res_c(res_c), .res_ov(res_ov), .res_valid(res_valid),
        .stage(stage), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && dut.u_db.pressed) pulses++;

    // returns {y, cout, ov}
    function automatic logic [4:0] alu_ref(input logic [2:0] a, input logic [2:0] b, input logic [3:0] f);
        int ua, ub, sa, sb, r;
        logic [2:0] y;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 4) ? ua - 8 : ua;
        sb = (ub >= 4) ? ub - 8 : ub;
        y = '0; c = 1'b0; v = 1'b0; r = 0;
        case (f)
            F_ADD, F_ADDU: begin
                r = ua + ub; y = 3'(r % 8); c = (r >= 8);
                if (f == F_ADD) v = (sa + sb > 3) || (sa + sb < -4);
            end
            F_SUB, F_SUBU: begin
                r = ua + (7 - ub) + 1; y = 3'(r % 8); c = (r >= 8);
                if (f == F_SUB) v = (sa - sb > 3) || (sa - sb < -4);
            end
            F_SLT:  y = (sa < sb) ? 3'd1 : 3'd0;
            F_SLTU: y = (ua < ub) ? 3'd1 : 3'd0;
            F_AND:  y = a & b;
            F_OR:   y = a | b;
            F_XOR:  y = a ^ b;
            F_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
        return {y, c, v};
    endfunction

    assign {alu_y, alu_cout, alu_ov} = alu_ref(alu_a, alu_b, alu_f);

    task automatic model_reset();
        m_a = '0; m_b = '0; m_f = '0; m_res = '0; m_valid = 1'b0; m_stage = 0; m_cnt = 0;
    endtask

    task automatic model_load(input logic [2:0] d, input logic [3:0] f);
        case (m_stage)
            1: begin m_b = d; m_stage = 2; end
            2: begin
                m_f = f; m_res = alu_ref(m_a, m_b, m_f);
                m_valid = 1'b1; m_cnt = (m_cnt + 1) % 4; m_stage = 3;
            end
            default: begin m_a = d; m_valid = 1'b0; m_stage = 1; end
        endcase
    endtask

    task automatic press(input logic [2:0] d, input logic [3:0] f);
        @(negedge clk);
        data_in = d; func_in = f; key_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        model_load(d, f);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, stage, op_count} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%0d b=%0d f=%0d y=%0d c=%0d ov=%0d v=%0d st=%0d cnt=%0d, want all 0",
                     alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, stage, op_count);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({stage, res_valid, op_count} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: got st=%0d v=%0d cnt=%0d, want 0 0 0", stage, res_valid, op_count);
        end
    endtask

    task automatic test_add();
        press(3'd3, 4'd0);
        n_checks++;
        if (stage !== 2'd1 || alu_a !== 3'd3) begin
            n_fail++; $display("FAIL add_load_a: got st=%0d a=%0d, want 1 3", stage, alu_a);
        end
        press(3'd5, 4'd0);
        press(3'd0, F_ADD);
        n_checks++;
        if ({res_y, res_c, res_ov, res_valid} !== {3'b000, 1'b1, 1'b0, 1'b1} || op_count !== 2'd1 || stage !== 2'd3) begin
            n_fail++;
            $display("FAIL add_result: got y=%b c=%b ov=%b v=%b cnt=%0d st=%0d, want 000 1 0 1 1 3",
                     res_y, res_c, res_ov, res_valid, op_count, stage);
        end
    endtask

    task automatic test_sub();
        press(3'd3, 4'd0);
        n_checks++;
        if (res_valid !== 1'b0 || res_y !== 3'b000) begin
            n_fail++; $display("FAIL new_a_drops_valid: got v=%b y=%b, want 0 000", res_valid, res_y);
        end
        press(3'd5, 4'd0);
        press(3'd0, F_SUB);
        n_checks++;
        if ({res_y, res_c, res_ov, res_valid} !== {3'b110, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sub_result: got y=%b c=%b ov=%b v=%b, want 110 0 1 1", res_y, res_c, res_ov, res_valid);
        end
        press(3'd3, 4'd0);
        press(3'd5, 4'd0);
        press(3'd0, F_SLTU);
        n_checks++;
        if (res_y !== 3'b001 || res_valid !== 1'b1 || op_count !== 2'd3) begin
            n_fail++; $display("FAIL sltu_result: got y=%b v=%b cnt=%0d, want 001 1 3", res_y, res_valid, op_count);
        end
    endtask

    task automatic test_bounce();
        int p0;
        logic [2:0] d;
        d = 3'($urandom_range(0, 7));
        @(negedge clk);
        data_in = d;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            key_n = ~key_n;
            @(negedge clk);
        end
        key_n = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (pulses - p0 != 1 || stage !== 2'd1 || alu_a !== d) begin
            n_fail++;
            $display("FAIL bounce_one_pulse: got pulses=%0d st=%0d a=%0d, want 1 1 %0d", pulses - p0, stage, alu_a, d);
        end
        repeat (50) @(negedge clk);
        key_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        n_checks++;
        if (pulses - p0 != 1 || stage !== 2'd1) begin
            n_fail++; $display("FAIL bounce_hold_release: got pulses=%0d st=%0d, want 1 1", pulses - p0, stage);
        end
        model_load(d, 4'd0);
    endtask

    task automatic test_clear_load();
        int t;
        logic [2:0] d;
        bit seen;
        d = ~m_b;
        seen = 1'b0;
        @(negedge clk);
        data_in = d; key_n = 1'b0;
        for (t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (dut.u_db.pressed) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL clear_wait_pulse: got no load pulse in 30 clocks, want one");
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (stage !== 2'd0 || alu_b !== m_b || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_beats_load: got st=%0d b=%0d v=%b, want 0 %0d 0", stage, alu_b, res_valid, m_b);
        end
        repeat (HOLD) @(negedge clk);
        key_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        m_stage = 0; m_valid = 1'b0;
        d = 3'($urandom_range(0, 7));
        press(d, 4'd0);
        n_checks++;
        if (stage !== 2'd1 || alu_a !== d || op_count !== 2'(m_cnt)) begin
            n_fail++; $display("FAIL press_after_clear: got st=%0d a=%0d cnt=%0d, want 1 %0d %0d", stage, alu_a, op_count, d, m_cnt);
        end
    endtask

    task automatic run_op(input string tag);
        logic [3:0] fl [10];
        fl = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
        while (m_stage != 0 && m_stage != 3) press(3'($urandom_range(0, 7)), 4'd0);
        press(3'($urandom_range(0, 7)), 4'd0);
        press(3'($urandom_range(0, 7)), 4'd0);
        press(3'd0, fl[$urandom_range(0, 9)]);
        n_checks++;
        if ({res_y, res_c, res_ov, res_valid} !== {m_res, m_valid} || op_count !== 2'(m_cnt) ||
            {alu_a, alu_b, alu_f} !== {m_a, m_b, m_f}) begin
            n_fail++;
            $display("FAIL %s: got a=%0d b=%0d f=%b y=%b c=%b ov=%b v=%b cnt=%0d, want a=%0d b=%0d f=%b ycv=%b v=1 cnt=%0d",
                     tag, alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, op_count,
                     m_a, m_b, m_f, m_res, m_cnt);
        end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 4; i++) run_op("random_op");
    endtask

    task automatic test_wrap_abort();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) run_op("wrap_op");
        n_checks++;
        if (op_count !== 2'd3) begin
            n_fail++; $display("FAIL count_three: got %0d, want 3", op_count);
        end
        run_op("wrap_op4");
        n_checks++;
        if (op_count !== 2'd0) begin
            n_fail++; $display("FAIL count_wrap: got %0d, want 0", op_count);
        end
        press(3'd6, 4'd0);
        press(3'd2, 4'd0);
        n_checks++;
        if (stage !== 2'd2 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL before_abort: got st=%0d v=%b, want 2 0", stage, res_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, stage, op_count} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_mid_seq: got a=%0d b=%0d f=%0d y=%0d c=%0d ov=%0d v=%0d st=%0d cnt=%0d, want all 0",
                     alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, stage, op_count);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_bounce();
        test_clear_load();
        test_random_ops();
        test_wrap_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
